// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared state type and constants for the adder scheduler
package adder_sched_pkg;
  localparam int ADDER_DATA_W = 8;
  localparam int MAX_ADD_LAT  = 7;
  localparam int LAT_CNT_W    = $clog2(MAX_ADD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with optional grant lock
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_lock_en,
  input  logic [ID_W-1:0]    i_lock_id,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_id
);
  logic [ID_W-1:0] w_idx;

  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    w_idx    = '0;
    if (i_lock_en) begin
      if (i_req[i_lock_id]) begin
        o_gnt[i_lock_id] = 1'b1;
        o_gnt_id         = i_lock_id;
      end
    end else begin
      // Walk from the far end back toward i_ptr so the nearest request wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        w_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
        if (i_req[w_idx]) begin
          o_gnt        = '0;
          o_gnt[w_idx] = 1'b1;
          o_gnt_id     = w_idx;
        end
      end
    end
  end
endmodule

// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - round-robin sharing of one registered adder
// Optional chained-carry lock mode: ADDER_SCHED_LOCK_EN.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ADD_LAT = 1,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_REQ*ADDER_DATA_W-1:0]  i_req_a,
  input  logic [NUM_REQ*ADDER_DATA_W-1:0]  i_req_b,
  input  logic [NUM_REQ-1:0]               i_req_cin,
`ifdef ADDER_SCHED_LOCK_EN
  input  logic [NUM_REQ-1:0]               i_req_lock,
`endif
  output logic [ADDER_DATA_W-1:0]          o_add_a,
  output logic [ADDER_DATA_W-1:0]          o_add_b,
  output logic                             o_add_cin,
  input  logic [ADDER_DATA_W-1:0]          i_add_sum,
  input  logic                             i_add_cout,
  output logic                             o_rsp_valid,
  input  logic                             i_rsp_ready,
  output logic [ID_W-1:0]                  o_rsp_id,
  output logic [ADDER_DATA_W-1:0]          o_rsp_sum,
  output logic                             o_rsp_cout,
  output logic                             o_busy
);
  sched_state_t            r_state;
  logic [ID_W-1:0]         r_rr_ptr;
  logic [ID_W-1:0]         r_cur_id;
  logic [LAT_CNT_W-1:0]    r_lat_cnt;
  logic [ADDER_DATA_W-1:0] r_add_a;
  logic [ADDER_DATA_W-1:0] r_add_b;
  logic                    r_add_cin;
  logic                    r_rsp_valid;
  logic [ID_W-1:0]         r_rsp_id;
  logic [ADDER_DATA_W-1:0] r_rsp_sum;
  logic                    r_rsp_cout;

  logic [NUM_REQ-1:0]      w_gnt;
  logic [ID_W-1:0]         w_gnt_id;
  logic [ID_W-1:0]         w_next_ptr;
  logic                    w_accept;
  logic                    w_lock_en;
  logic [ID_W-1:0]         w_lock_id;
  logic                    w_cin;

`ifdef ADDER_SCHED_LOCK_EN
  logic                    r_locked;
  logic [ID_W-1:0]         r_lock_id;

  assign w_lock_en = r_locked;
  assign w_lock_id = r_lock_id;
  // Inside a chain the carry comes from the previous byte's result.
  assign w_cin     = r_locked ? r_rsp_cout : i_req_cin[w_gnt_id];
`else
  assign w_lock_en = 1'b0;
  assign w_lock_id = '0;
  assign w_cin     = i_req_cin[w_gnt_id];
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req     (i_req_valid),
    .i_ptr     (r_rr_ptr),
    .i_lock_en (w_lock_en),
    .i_lock_id (w_lock_id),
    .o_gnt     (w_gnt),
    .o_gnt_id  (w_gnt_id)
  );

  assign w_accept    = (r_state == S_IDLE) && (|w_gnt);
  assign w_next_ptr  = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
  assign o_req_ready = ((r_state == S_IDLE) && !rst) ? w_gnt : '0;
  assign o_busy      = (r_state != S_IDLE);
  assign o_add_a     = r_add_a;
  assign o_add_b     = r_add_b;
  assign o_add_cin   = r_add_cin;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_cout  = r_rsp_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_cur_id    <= '0;
      r_lat_cnt   <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_cin   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
`ifdef ADDER_SCHED_LOCK_EN
      r_locked    <= 1'b0;
      r_lock_id   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_add_a   <= i_req_a[ADDER_DATA_W*w_gnt_id +: ADDER_DATA_W];
            r_add_b   <= i_req_b[ADDER_DATA_W*w_gnt_id +: ADDER_DATA_W];
            r_add_cin <= w_cin;
            r_cur_id  <= w_gnt_id;
            r_rr_ptr  <= w_next_ptr;
            r_state   <= S_ISSUE;
`ifdef ADDER_SCHED_LOCK_EN
            r_locked  <= i_req_lock[w_gnt_id];
            r_lock_id <= w_gnt_id;
`endif
          end
        end
        S_ISSUE: begin
          r_lat_cnt <= LAT_CNT_W'(ADD_LAT - 1);
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat_cnt != '0) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end else begin
            r_rsp_sum   <= i_add_sum;
            r_rsp_cout  <= i_add_cout;
            r_rsp_id    <= r_cur_id;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb/tb_adder_rr_scheduler.sv - self-checking bench with a transaction-level model
module tb_adder_rr_scheduler;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_cin;
  logic [31:0] req_a, req_b;
`ifdef ADDER_SCHED_LOCK_EN
  logic [3:0]  req_lock;
`endif
  logic [7:0]  add_a, add_b, add_sum, rsp_sum;
  logic        add_cin, add_cout, rsp_valid, rsp_ready, rsp_cout, busy;
  logic [1:0]  rsp_id;

  logic        rst4;
  logic [3:0]  v4, ready4, cin4;
  logic [31:0] a4, b4;
`ifdef ADDER_SCHED_LOCK_EN
  logic [3:0]  lock4;
`endif
  logic [7:0]  add4_a, add4_b, add4_sum, rsp4_sum;
  logic        add4_cin, add4_cout, rv4, rr4, rsp4_cout, busy4;
  logic [1:0]  rsp4_id;
  logic [8:0]  pipe4 [0:3];

  always #5 clk = ~clk;

  adder_rr_scheduler #(.NUM_REQ(4), .ADD_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_cin(req_cin),
`ifdef ADDER_SCHED_LOCK_EN
    .i_req_lock(req_lock),
`endif
    .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
    .i_add_sum(add_sum), .i_add_cout(add_cout),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_sum(rsp_sum), .o_rsp_cout(rsp_cout), .o_busy(busy)
  );

  adder_rr_scheduler #(.NUM_REQ(4), .ADD_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst4),
    .i_req_valid(v4), .o_req_ready(ready4),
    .i_req_a(a4), .i_req_b(b4), .i_req_cin(cin4),
`ifdef ADDER_SCHED_LOCK_EN
    .i_req_lock(lock4),
`endif
    .o_add_a(add4_a), .o_add_b(add4_b), .o_add_cin(add4_cin),
    .i_add_sum(add4_sum), .i_add_cout(add4_cout),
    .o_rsp_valid(rv4), .i_rsp_ready(rr4), .o_rsp_id(rsp4_id),
    .o_rsp_sum(rsp4_sum), .o_rsp_cout(rsp4_cout), .o_busy(busy4)
  );

  // Shared adders: 1-cycle and 4-cycle registered a+b+cin.
  always @(posedge clk) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  always @(posedge clk) begin
    pipe4[0] <= {1'b0, add4_a} + {1'b0, add4_b} + {8'd0, add4_cin};
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign {add4_cout, add4_sum} = pipe4[3];

  int errors = 0, checks = 0, cyc = 0;
  bit m_busy, m_locked;
  int m_acc_cyc, m_rsp_cyc, m_ptr, m_lock_id, last_grant, n_rsps;
  logic [7:0] m_a, m_b, m_sum;
  logic [1:0] m_id;
  logic m_cin, m_cout, m_last_cout;
  logic [3:0] s_ready;
  logic [7:0] s_sum, s_add_a, s_add_b;
  logic [1:0] s_id;
  logic s_busy, s_rv, s_cout, s_add_cin;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: compare the DUT with the model at negedge, then advance the model.
  task automatic tick();
    int g;
    bit exp_rv;
    @(negedge clk);
    s_ready = req_ready; s_busy = busy; s_rv = rsp_valid; s_id = rsp_id;
    s_sum = rsp_sum; s_cout = rsp_cout; s_add_a = add_a; s_add_b = add_b; s_add_cin = add_cin;
    last_grant = -1;
    if (rst) begin
      chk("rst_ready", s_ready, 0); chk("rst_busy", s_busy, 0);
      chk("rst_rsp_valid", s_rv, 0); chk("rst_rsp_sum", s_sum, 0);
      chk("rst_add_a", s_add_a, 0); chk("rst_rsp_id", s_id, 0);
      m_busy = 0; m_ptr = 0; m_locked = 0; m_last_cout = 0;
    end else begin
      g = -1;
      if (!m_busy) begin
        if (m_locked) begin
          if (req_valid[m_lock_id]) g = m_lock_id;
        end else begin
          for (int k = 0; k < 4; k++)
            if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
      end
      exp_rv = m_busy && (cyc >= m_rsp_cyc);
      chk("req_ready", s_ready, (g >= 0) ? 4'(1 << g) : 4'b0);
      chk("busy", s_busy, m_busy);
      chk("rsp_valid", s_rv, exp_rv);
      if (exp_rv) begin
        chk("rsp_id", s_id, m_id); chk("rsp_sum", s_sum, m_sum); chk("rsp_cout", s_cout, m_cout);
      end
      if (m_busy && cyc > m_acc_cyc) begin
        chk("add_a", s_add_a, m_a); chk("add_b", s_add_b, m_b); chk("add_cin", s_add_cin, m_cin);
      end
      if (m_busy && cyc == m_rsp_cyc) m_last_cout = m_cout;
      if (g >= 0) begin
        m_a = req_a[8*g +: 8]; m_b = req_b[8*g +: 8];
        m_cin = m_locked ? m_last_cout : req_cin[g];
        {m_cout, m_sum} = {1'b0, m_a} + {1'b0, m_b} + {8'd0, m_cin};
        m_id = 2'(g); m_busy = 1; m_acc_cyc = cyc; m_rsp_cyc = cyc + 2 + LAT;
`ifdef ADDER_SCHED_LOCK_EN
        m_locked = req_lock[g]; m_lock_id = g;
`endif
        m_ptr = (g + 1) % 4; last_grant = g;
      end else if (exp_rv && rsp_ready) begin
        m_busy = 0; n_rsps++;
      end
    end
    @(posedge clk); cyc++; #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin tick(); n++; end while (!s_rv && n < 20);
    if (!s_rv) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_grant(output int g);
    int n = 0;
    do begin tick(); n++; end while (last_grant < 0 && n < 30);
    g = last_grant;
    if (g < 0) chk("grant_timeout", 0, 1);
  endtask

  task automatic do_single(input int r, input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [7:0] es, input logic ec, input string nm);
    int n;
    req_valid = 4'(1 << r); req_a[8*r +: 8] = a; req_b[8*r +: 8] = b; req_cin[r] = c;
    rsp_ready = 1;
    tick();
    chk({nm, "_grant"}, last_grant, r);
    req_valid = 0;
    wait_rsp(n);
    chk({nm, "_latency"}, n, 3);
    chk({nm, "_id"}, s_id, r); chk({nm, "_sum"}, s_sum, es); chk({nm, "_cout"}, s_cout, ec);
  endtask

  initial begin
    int n, g;
    int order [8];
    rst = 1; req_valid = 0; req_a = 0; req_b = 0; req_cin = 0; rsp_ready = 0;
`ifdef ADDER_SCHED_LOCK_EN
    req_lock = 0; lock4 = 0;
`endif
    rst4 = 1; v4 = 0; a4 = 0; b4 = 0; cin4 = 0; rr4 = 1;
    #1;
    repeat (3) tick();
    rst = 0;

    do_single(2, 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0, "single");
    do_single(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf1");
    do_single(3, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ovf2");

    // Fairness from reset
    rst = 1; tick(); rst = 0;
    req_valid = 4'hF; req_a = $urandom; req_b = $urandom; rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      wait_grant(g); order[i] = g;
    end
    for (int i = 0; i < 8; i++) chk($sformatf("fair_order%0d", i), order[i], i % 4);
    req_valid = 0;
    wait_rsp(n);
    tick();

    // Backpressure: requester 1 (ptr is 0 here, only 1 valid)
    rsp_ready = 0; req_valid = 4'b0010; req_a[15:8] = 8'h10; req_b[15:8] = 8'h20; req_cin[1] = 0;
    tick();
    chk("bp_grant", last_grant, 1);
    req_valid = 4'hF;
    wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready_zero", s_ready, 0); chk("bp_rv", s_rv, 1);
      chk("bp_sum", s_sum, 8'h30); chk("bp_id", s_id, 1);
    end
    req_valid = 0; rsp_ready = 1; n = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (s_rv) n++; end
    chk("bp_one_response", n, 1);

`ifdef ADDER_SCHED_LOCK_EN
    rst = 1; tick(); rst = 0;
    do_single(0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "lk_pre");
    req_valid = 4'b0011; req_a[15:8] = 8'hFF; req_b[15:8] = 8'h01; req_cin[1] = 0; req_lock[1] = 1;
    tick();
    chk("lk_grant_lo", last_grant, 1);
    req_a[15:8] = 8'h00; req_b[15:8] = 8'h00; req_cin[1] = 0; req_lock[1] = 0;
    wait_rsp(n);
    chk("lk_lo_sum", s_sum, 8'h00); chk("lk_lo_cout", s_cout, 1); chk("lk_lo_id", s_id, 1);
    wait_grant(g); chk("lk_grant_hi", g, 1);
    wait_rsp(n);
    chk("lk_hi_sum", s_sum, 8'h01); chk("lk_hi_cout", s_cout, 0); chk("lk_hi_id", s_id, 1);
    wait_grant(g); chk("lk_grant_after", g, 0);
    req_valid = 0; wait_rsp(n); req_lock = 0;
`endif

    // Randomized traffic with occasional resets
    n_rsps = 0;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      req_valid = 4'($urandom); req_a = $urandom; req_b = $urandom; req_cin = 4'($urandom);
`ifdef ADDER_SCHED_LOCK_EN
      req_lock = 4'($urandom) & 4'($urandom);
`endif
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 0; req_valid = 0;
    chk("random_activity", (n_rsps > 20), 1);

    // Reset mid-WAIT on the 4-cycle instance
    rst4 = 0; v4 = 4'b0001; a4 = 32'h0000_0011; b4 = 32'h0000_0022;
    @(negedge clk); chk("r4_first_grant", ready4, 4'b0001);
    @(posedge clk); #1; v4 = 0;
    repeat (3) @(negedge clk);
    chk("r4_busy_wait", busy4, 1);
    @(posedge clk); #1; rst4 = 1;
    @(negedge clk);
    chk("r4_rst_busy", busy4, 0); chk("r4_rst_add_a", add4_a, 0); chk("r4_rst_add_b", add4_b, 0);
    chk("r4_rst_rv", rv4, 0); chk("r4_rst_sum", rsp4_sum, 0); chk("r4_rst_ready", ready4, 0);
    @(posedge clk); #1; rst4 = 0;
    n = 0;
    repeat (10) begin @(negedge clk); if (rv4) n++; end
    chk("r4_no_response", n, 0);
    @(posedge clk); #1; v4 = 4'b0101;
    @(negedge clk); chk("r4_grant_after_rst", ready4, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_rr_scheduler.md
# adder_rr_scheduler

Round-robin scheduler that shares one registered 8-bit adder (`a + b + cin` → `sum`, `cout`, fixed latency) among `NUM_REQ` requesters. It accepts one operation at a time through per-requester valid/ready handshakes and drives the adder's operand inputs. It waits out the adder latency, then returns the result tagged with the requester ID through a valid/ready response port. The block sits between the client units and the shared adder instance. As an optional feature, it holds the adder for multi-byte chained additions.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADD_LAT`, 1: adder latency in clocks from operands sampled to `add_sum`/`add_cout` valid, 1..7.
- `ID_W`, `$clog2(NUM_REQ)`: response ID width, derived, not overridden.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in NUM_REQ: per-requester operation valid.
- `req_ready` out NUM_REQ: per-requester accept, at most one bit high (one-hot or zero).
- `req_a` in NUM_REQ*8: operand A; requester i uses bits [8i+7:8i].
- `req_b` in NUM_REQ*8: operand B, same packing as `req_a`.
- `req_cin` in NUM_REQ: carry-in.
- `req_lock` in NUM_REQ: chain-continue flag. Present only with `ADDER_SCHED_LOCK_EN`.
- `add_a`, `add_b` out 8: registered operands to the adder.
- `add_cin` out 1: registered carry-in to the adder.
- `add_sum` in 8, `add_cout` in 1: adder results.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out ID_W: index of the requester that issued the operation.
- `rsp_sum` out 8, `rsp_cout` out 1: registered result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is high, pick the winner g: the first valid index searched from `rr_ptr` upward, wrapping modulo NUM_REQ.
  - `req_ready[g]` is asserted combinationally in the same cycle, so it depends on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
  - On accept: latch `req_a[g]`, `req_b[g]`, `req_cin[g]` into `add_a`/`add_b`/`add_cin` and g into `cur_id`. Set `rr_ptr` ← (g+1) mod NUM_REQ. Go to ISSUE.
- ISSUE: operands are stable; the adder samples them at the end of this cycle. Load `lat_cnt` ← ADD_LAT−1. Go to WAIT.
- WAIT:
  - While `lat_cnt` ≠ 0, decrement it.
  - When `lat_cnt` = 0, `add_sum`/`add_cout` are valid. Capture them into `rsp_sum`/`rsp_cout`, set `rsp_id` ← `cur_id`, set `rsp_valid` ← 1. Go to RESP.
- RESP:
  - `rsp_valid` and all response fields are held stable until `rsp_ready` is high.
  - On the handshake, clear `rsp_valid` and go to IDLE.
  - No new request is accepted in RESP. `req_ready` is all-zero outside IDLE.
- `add_*` outputs hold their last value between operations.
- Width: the result is exactly the adder's 9 bits; the block does no arithmetic of its own. Example: 8'hFF + 8'h01 + 0 → sum 8'h00, cout 1.
- Reset:
  - All outputs go to 0: `req_ready`, `add_a`, `add_b`, `add_cin`, `rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_cout`, `busy`.
  - Internal state: `rr_ptr` 0, `lat_cnt` 0, state IDLE.
  - Reset during any state abandons the operation and emits no response.
- A requester dropping `req_valid` after acceptance has no effect on the operation in flight.

## Timing
- Accept at cycle t, with `req_valid[g]` and `req_ready[g]` high. `add_*` are valid from t+1. `rsp_valid` rises at t+2+ADD_LAT.
- With ADD_LAT=1, `rsp_valid` is high at t+3.
- Maximum throughput is one operation per 3+ADD_LAT cycles, with `rsp_ready` tied high.
- The response handshake at cycle r allows the next accept at r+1 at the earliest.

## Configuration
- `ADDER_SCHED_LOCK_EN` defined:
  - `req_lock` port exists.
  - When an accepted operation has `req_lock[g]`=1, the block enters locked mode on g.
  - In locked mode only requester g can be granted, and `rr_ptr` is frozen. The lock persists even while `req_valid[g]` is low.
  - The next accepted operation from g uses the stored `rsp_cout` of the previous result as `add_cin`; `req_cin[g]` is ignored.
  - An accepted operation with `req_lock[g]`=0 is the last of the chain. It also uses the chained carry, releases the lock, and advances `rr_ptr` to g+1.
  - Reset clears the lock.
- Macro undefined: no `req_lock` port, no locked mode; arbitration is always round-robin and `add_cin` is always `req_cin[g]`.

## Structure
- `adder_sched_pkg` holds:
  - the state enum type (IDLE/ISSUE/WAIT/RESP);
  - `ADDER_DATA_W` = 8;
  - `MAX_ADD_LAT` = 7.
- Sub-module `rr_arbiter`: combinational. Takes `req[NUM_REQ]`, `ptr`, and an optional `lock_en`/`lock_id`. Produces one-hot `gnt` and `gnt_id`. Reusable by the team's other shared-resource schedulers.
- The FSM, latency counter, operand registers and response registers stay in the top module.

## Test plan
- Single request: requester 2 sends a=8'h3C, b=8'h42, cin=1 with ADD_LAT=1 → `rsp_valid` 3 cycles after accept, `rsp_id`=2, sum=8'h7F, cout=0.
- Overflow: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Also a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Fairness: all 4 requesters held valid for 8 operations from reset → grant order 0,1,2,3,0,1,2,3, with no requester granted twice before the others.
- Backpressure: `rsp_ready` held low 5 cycles in RESP → response fields stable, `req_ready` all-zero, exactly one response on release.
- Reset mid-WAIT with ADD_LAT=4 → all outputs 0 next cycle, no response emitted, next grant goes to requester 0.
- Lock (macro defined): requester 1 issues 16-bit 0x00FF+0x0001 as a locked low byte then an unlocked high byte, while requester 0 is also valid → responses sum=8'h00 cout=1, then sum=8'h01 cout=0, both with id 1. Requester 0 is granted next.
